multi_cycle_controller: RTL and testbench

- Sequencing FSM for the multi-cycle MIPS-subset datapath: owns the state register, dispatches on opcode, and drives the 16 datapath control lines each cycle.
- Adds memory wait-state stalling, a global enable/freeze, illegal-opcode trapping and a retired-instruction counter.
- Sits between instruction register / memory-ready logic and the datapath.

---
 rtl/multi_cycle_pkg.sv | 69 ++++++
 rtl/mc_ctrl_decode.sv | 70 +++++++
 rtl/multi_cycle_controller.sv | 85 ++++++++
 tb/tb_multi_cycle_controller.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_pkg.sv
// Shared types and constants for the multi-cycle MIPS-subset controller:
// state encodings, opcodes, control-bus bit positions and field encodings.
package multi_cycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_TRAP   = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam int CTRL_W = 16;

    // Single-bit control lines
    localparam int B_PC_WRITE      = 15;
    localparam int B_PC_WRITE_COND = 14;
    localparam int B_I_OR_D        = 13;
    localparam int B_MEM_READ      = 12;
    localparam int B_MEM_WRITE     = 11;
    localparam int B_IR_WRITE      = 10;
    localparam int B_MEM_TO_REG    = 9;
    localparam int B_ALU_SRC_A     = 2;
    localparam int B_REG_WRITE     = 1;
    localparam int B_REG_DST       = 0;

    // Two-bit mux-select fields (LSB positions)
    localparam int F_PC_SOURCE = 7;
    localparam int F_ALU_OP    = 5;
    localparam int F_ALU_SRC_B = 3;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG      = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_IMM      = 2'b10;
    localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

    // Lines that change architectural state; these are dropped while frozen,
    // the mux selects are left alone so the datapath stays stable.
    localparam logic [CTRL_W-1:0] WRITE_MASK =
        (CTRL_W'(1) << B_PC_WRITE)  | (CTRL_W'(1) << B_PC_WRITE_COND) |
        (CTRL_W'(1) << B_MEM_READ)  | (CTRL_W'(1) << B_MEM_WRITE)     |
        (CTRL_W'(1) << B_IR_WRITE)  | (CTRL_W'(1) << B_REG_WRITE);

    function automatic logic is_retire_state(input state_t s);
        return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_RWB) ||
               (s == S_BRANCH) || (s == S_JUMP);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control-bus decoder: current state plus mem_ready/enable
// produce the 16 datapath control lines.
module mc_ctrl_decode
    import multi_cycle_pkg::*;
(
    input  state_t              state,
    input  logic                mem_ready,
    input  logic                enable,
    output logic [CTRL_W-1:0]   ctrl
);

    logic [CTRL_W-1:0] raw;

    always_comb begin
        raw = '0;
        raw[F_PC_SOURCE +: 2] = PCS_ALU;
        raw[F_ALU_OP    +: 2] = ALUOP_ADD;
        raw[F_ALU_SRC_B +: 2] = SRCB_REG;
        case (state)
            S_FETCH: begin
                raw[B_MEM_READ]       = 1'b1;
                raw[F_ALU_SRC_B +: 2] = SRCB_FOUR;
                // PC and IR only commit on the cycle memory delivers the word
                raw[B_PC_WRITE]       = mem_ready;
                raw[B_IR_WRITE]       = mem_ready;
            end
            S_DECODE: begin
                raw[F_ALU_SRC_B +: 2] = SRCB_IMM_SHL2;
            end
            S_MEMADR: begin
                raw[B_ALU_SRC_A]      = 1'b1;
                raw[F_ALU_SRC_B +: 2] = SRCB_IMM;
            end
            S_MEMRD: begin
                raw[B_MEM_READ] = 1'b1;
                raw[B_I_OR_D]   = 1'b1;
            end
            S_MEMWB: begin
                raw[B_REG_WRITE]  = 1'b1;
                raw[B_MEM_TO_REG] = 1'b1;
            end
            S_MEMWR: begin
                raw[B_MEM_WRITE] = 1'b1;
                raw[B_I_OR_D]    = 1'b1;
            end
            S_EXEC: begin
                raw[B_ALU_SRC_A]   = 1'b1;
                raw[F_ALU_OP +: 2] = ALUOP_FUNCT;
            end
            S_RWB: begin
                raw[B_REG_WRITE] = 1'b1;
                raw[B_REG_DST]   = 1'b1;
            end
            S_BRANCH: begin
                raw[B_ALU_SRC_A]      = 1'b1;
                raw[F_ALU_OP +: 2]    = ALUOP_SUB;
                raw[B_PC_WRITE_COND]  = 1'b1;
                raw[F_PC_SOURCE +: 2] = PCS_ALUOUT;
            end
            S_JUMP: begin
                raw[B_PC_WRITE]       = 1'b1;
                raw[F_PC_SOURCE +: 2] = PCS_JUMP;
            end
            default: raw = '0;
        endcase
    end

    assign ctrl = enable ? raw : (raw & ~WRITE_MASK);

endmodule

// File: rtl/multi_cycle_controller.sv
// Sequencing FSM for the multi-cycle datapath: state register, opcode latch,
// retired-instruction counter and sticky illegal-opcode flag.
module multi_cycle_controller
    import multi_cycle_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic [CTRL_W-1:0]  ctrl,
    output logic [3:0]         state_out,
    output logic               illegal,
    output logic [CNT_W-1:0]   instr_count
);

    state_t            state_q;
    state_t            state_d;
    logic [5:0]        op_q;
    logic [CTRL_W-1:0] dec_ctrl;
    logic              retire;
    logic              trap_entry;

    always_comb begin
        state_d = state_q;
        if (enable) begin
            case (state_q)
                S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_RTYPE:     state_d = S_EXEC;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_J:         state_d = S_JUMP;
                        default:      state_d = S_TRAP;
                    endcase
                end
                S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
                S_MEMWB:  state_d = S_FETCH;
                S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
                S_EXEC:   state_d = S_RWB;
                S_RWB:    state_d = S_FETCH;
                S_BRANCH: state_d = S_FETCH;
                S_JUMP:   state_d = S_FETCH;
                S_TRAP:   state_d = S_TRAP;
                default:  state_d = S_TRAP;
            endcase
        end
    end

    // An instruction retires on the hand-back to FETCH from a terminal state
    assign retire     = enable && (state_d == S_FETCH) && is_retire_state(state_q);
    assign trap_entry = enable && (state_d == S_TRAP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            op_q        <= '0;
            instr_count <= '0;
            illegal     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (enable && (state_q == S_DECODE))
                op_q <= opcode;
            if (retire)
                instr_count <= instr_count + CNT_W'(1);
            if (trap_entry)
                illegal <= 1'b1;
        end
    end

    mc_ctrl_decode u_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .enable    (enable),
        .ctrl      (dec_ctrl)
    );

    assign ctrl      = reset ? '0 : dec_ctrl;
    assign state_out = state_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Scoreboard bench for multi_cycle_controller with a 4-bit counter so the
// retired-instruction wrap is reachable.
module tb_multi_cycle_controller;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [5:0]    opcode;
    logic          mem_ready;
    logic [15:0]   ctrl;
    logic [3:0]    state_out;
    logic          illegal;
    logic [CW-1:0] instr_count;

    multi_cycle_controller #(.CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .ctrl        (ctrl),
        .state_out   (state_out),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]    st;
        logic [15:0]   ct;
        logic          il;
        logic [CW-1:0] cn;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int         m_state;
    logic [5:0] m_opq;
    logic       m_ill;
    logic [CW-1:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_ctrl(int s, logic r, logic e, logic mr);
        logic [15:0] c;
        case (s)
            0:  c = mr ? 16'h9408 : 16'h1008;
            1:  c = 16'h0018;
            2:  c = 16'h0014;
            3:  c = 16'h3000;
            4:  c = 16'h0202;
            5:  c = 16'h2800;
            6:  c = 16'h0044;
            7:  c = 16'h0003;
            8:  c = 16'h40A4;
            9:  c = 16'h8100;
            default: c = 16'h0000;
        endcase
        if (!e) c = c & 16'h23FD;
        if (r)  c = 16'h0000;
        return c;
    endfunction

    function automatic int model_next(int s, logic [5:0] op, logic [5:0] oq, logic mr);
        case (s)
            0: return mr ? 1 : 0;
            1: begin
                if (op == 6'b100011 || op == 6'b101011) return 2;
                if (op == 6'b000000) return 6;
                if (op == 6'b000100) return 8;
                if (op == 6'b000010) return 9;
                return 10;
            end
            2: return (oq == 6'b100011) ? 3 : 5;
            3: return mr ? 4 : 3;
            4, 7, 8, 9: return 0;
            5: return mr ? 0 : 5;
            6: return 7;
            default: return 10;
        endcase
    endfunction

    task automatic step(input logic r, input logic e, input logic [5:0] op, input logic mr);
        exp_t x;
        int   nx;
        @(negedge clk);
        reset = r; enable = e; opcode = op; mem_ready = mr;
        sb.push_back('{st: m_state[3:0], ct: model_ctrl(m_state, r, e, mr), il: m_ill, cn: m_cnt});
        #1;
        x = sb.pop_front();
        check("state", 32'(state_out), 32'(x.st));
        check("ctrl", 32'(ctrl), 32'(x.ct));
        check("illegal", 32'(illegal), 32'(x.il));
        check("instr_count", 32'(instr_count), 32'(x.cn));
        @(posedge clk);
        if (r) begin
            m_state = 0; m_opq = '0; m_ill = 1'b0; m_cnt = '0;
        end else if (e) begin
            nx = model_next(m_state, op, m_opq, mr);
            if (m_state == 1) m_opq = op;
            if (nx == 0 && (m_state == 4 || m_state == 5 || m_state >= 7 && m_state <= 9))
                m_cnt = m_cnt + 1'b1;
            if (nx == 10) m_ill = 1'b1;
            m_state = nx;
        end
    endtask

    task automatic run(input logic [5:0] op, input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b1, op, 1'b1);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; opcode = '0; mem_ready = 1'b0;
        @(posedge clk);
        m_state = 0; m_opq = '0; m_ill = 1'b0; m_cnt = '0;

        step(1'b1, 1'b1, 6'b000000, 1'b1);
        // lw, no stalls: 5 cycles
        run(6'b100011, 5);
        // R-type aborted by a 2-cycle reset in EXEC, then FETCH with ready
        run(6'b000000, 2);
        step(1'b1, 1'b1, 6'b000000, 1'b1);
        step(1'b1, 1'b0, 6'b000000, 1'b0);
        // sw with three wait states in MEMWR
        run(6'b101011, 3);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 6'b101011, 1'b0);
        step(1'b0, 1'b1, 6'b101011, 1'b1);
        // FETCH stall then R-type
        step(1'b0, 1'b1, 6'b000000, 1'b0);
        step(1'b0, 1'b1, 6'b000000, 1'b0);
        run(6'b000000, 4);
        // beq
        run(6'b000100, 3);
        // freeze in FETCH with mem_ready high: access not consumed
        step(1'b0, 1'b0, 6'b000010, 1'b1);
        step(1'b0, 1'b0, 6'b000010, 1'b1);
        // 16 jumps, freezing twice in the first JUMP state
        run(6'b000010, 2);
        step(1'b0, 1'b0, 6'b000010, 1'b1);
        step(1'b0, 1'b0, 6'b000010, 1'b0);
        run(6'b000010, 1);
        run(6'b000010, 45);
        // lw with a read wait state
        run(6'b100011, 3);
        step(1'b0, 1'b1, 6'b100011, 1'b0);
        run(6'b100011, 2);
        // illegal opcode, then random inputs while trapped
        run(6'b001000, 2);
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
        step(1'b1, 1'b1, 6'b001000, 1'b0);
        run(6'b100011, 5);
        step(1'b0, 1'b1, 6'b000000, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
